// File: rtl/out_port_alloc.sv
// -----------------------------------------------------------------------------
// out_port_alloc
//
// Output-port allocator for one router output. It collects the per-input
// request bits for this port, arbitrates round-robin among eligible inputs,
// and holds the grant for a whole wormhole packet. Downstream credits are
// tracked per VC, and grants are only issued while the link is up. A
// registered valid/VC/tail strobe describes the flit forwarded in the
// previous cycle.
//
// Build option:
//   ESCAPE_PRIO_EN - when defined, idle-state arbitration prefers eligible
//                    escape-VC (in_vc=1) requesters over normal-VC ones.
//                    Undefined (default): plain round-robin, VC-agnostic.
//
// Parameters:
//   N_IN          number of input units that may request this port
//   CREDIT_DEPTH  downstream buffer slots per VC (credit reset value)
//   CNT_W         credit counter width (must hold CREDIT_DEPTH)
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   req         req[i]: input i holds a flit routed to this port
//   in_vc       VC of input i's flit (0 = normal, 1 = escape)
//   in_tail     input i's current flit is a tail
//   link_up     output link available
//   credit_ret  one credit returned per VC this cycle
//   gnt         combinational one-hot grant; transfer when gnt[i] & req[i]
//   out_valid   registered: a flit was forwarded last cycle
//   out_vc      registered VC of the forwarded flit
//   out_tail    registered tail flag of the forwarded flit
//   locked      a packet is in progress
//   credit_err  sticky: credit returned to an already full counter
// -----------------------------------------------------------------------------
module out_port_alloc #(
    parameter int unsigned N_IN         = 8,
    parameter int unsigned CREDIT_DEPTH = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] req,
    input  logic [N_IN-1:0] in_vc,
    input  logic [N_IN-1:0] in_tail,
    input  logic            link_up,
    input  logic [1:0]      credit_ret,
    output logic [N_IN-1:0] gnt,
    output logic            out_valid,
    output logic            out_vc,
    output logic            out_tail,
    output logic            locked,
    output logic            credit_err
);

    localparam int unsigned      IDX_W     = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] CRED_FULL = CNT_W'(CREDIT_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_IN - 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             owner_vc_q, owner_vc_d;
    logic [CNT_W-1:0] credit_q [2];
    logic [CNT_W-1:0] credit_d [2];
    logic             credit_err_q, credit_err_d;
    logic             out_valid_q, out_valid_d;
    logic             out_vc_q, out_vc_d;
    logic             out_tail_q, out_tail_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [N_IN-1:0]  elig;
    logic [N_IN-1:0]  cand;
    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    int unsigned      arb_pos;
    logic             owner_elig;
    logic [N_IN-1:0]  gnt_c;
    logic             xfer;
    logic [IDX_W-1:0] xfer_idx;
    logic             xfer_vc;
    logic             xfer_tail;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            elig[i] = req[i] & link_up & (credit_q[in_vc[i]] != '0);
        end
    end

    // The owner's credit check uses the VC captured at the head flit, so
    // body flits are accounted against the same counter as the head.
    assign owner_elig = req[owner_q] & link_up & (credit_q[owner_vc_q] != '0);

    // Round-robin search starting just after rr_ptr_q, wrapping mod N_IN.
    always_comb begin
        cand = elig;
`ifdef ESCAPE_PRIO_EN
        // Restrict the pool to escape-VC requesters whenever any is eligible.
        if ((elig & in_vc) != '0) begin
            cand = elig & in_vc;
        end
`endif
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_pos   = 0;
        for (int unsigned k = 1; k <= N_IN; k++) begin
            arb_pos = 32'(rr_ptr_q) + k;
            if (arb_pos >= N_IN) begin
                arb_pos = arb_pos - N_IN;
            end
            if (!arb_found && cand[IDX_W'(arb_pos)]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(arb_pos);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM output logic: grant vector
    // ------------------------------------------------------------------
    always_comb begin
        gnt_c = '0;
        if (rst_n) begin
            if (state_q == ST_IDLE) begin
                if (arb_found) begin
                    gnt_c[arb_idx] = 1'b1;
                end
            end else begin
                gnt_c[owner_q] = owner_elig;
            end
        end
    end

    assign xfer      = |(gnt_c & req);
    assign xfer_idx  = (state_q == ST_LOCKED) ? owner_q : arb_idx;
    assign xfer_vc   = (state_q == ST_LOCKED) ? owner_vc_q : in_vc[arb_idx];
    assign xfer_tail = in_tail[xfer_idx];

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        owner_vc_d = owner_vc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (xfer_tail) begin
                        // Single-flit packet: no lock, advance the pointer.
                        rr_ptr_d = xfer_idx;
                    end else begin
                        state_d    = ST_LOCKED;
                        owner_d    = xfer_idx;
                        owner_vc_d = xfer_vc;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer && xfer_tail) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Credit counters and output strobe
    // ------------------------------------------------------------------
    always_comb begin
        credit_err_d = credit_err_q;
        for (int unsigned v = 0; v < 2; v++) begin
            credit_d[v] = credit_q[v];
            if (xfer && (xfer_vc == 1'(v))) begin
                // A simultaneous return cancels the decrement.
                if (!credit_ret[v]) begin
                    credit_d[v] = credit_q[v] - 1'b1;
                end
            end else if (credit_ret[v]) begin
                if (credit_q[v] == CRED_FULL) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + 1'b1;
                end
            end
        end

        out_valid_d = xfer;
        out_vc_d    = out_vc_q;
        out_tail_d  = out_tail_q;
        if (xfer) begin
            out_vc_d   = xfer_vc;
            out_tail_d = xfer_tail;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= LAST_IDX;
            owner_q      <= '0;
            owner_vc_q   <= 1'b0;
            credit_q[0]  <= CRED_FULL;
            credit_q[1]  <= CRED_FULL;
            credit_err_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_vc_q     <= 1'b0;
            out_tail_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            owner_vc_q   <= owner_vc_d;
            credit_q[0]  <= credit_d[0];
            credit_q[1]  <= credit_d[1];
            credit_err_q <= credit_err_d;
            out_valid_q  <= out_valid_d;
            out_vc_q     <= out_vc_d;
            out_tail_q   <= out_tail_d;
        end
    end

    assign gnt        = gnt_c;
    assign out_valid  = out_valid_q;
    assign out_vc     = out_vc_q;
    assign out_tail   = out_tail_q;
    assign locked     = (state_q == ST_LOCKED);
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_out_port_alloc.sv
// -----------------------------------------------------------------------------
// tb_out_port_alloc
//
// Directed testbench for out_port_alloc with N_IN=4. Expected values are
// hand-computed from the allocator behaviour: round-robin from rr_ptr+1,
// wormhole lock, per-VC credits starting at 4, link gating, sticky credit
// error, and synchronous reset.
// -----------------------------------------------------------------------------
module tb_out_port_alloc;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] in_vc;
    logic [N-1:0] in_tail;
    logic         link_up;
    logic [1:0]   credit_ret;
    logic [N-1:0] gnt;
    logic         out_valid;
    logic         out_vc;
    logic         out_tail;
    logic         locked;
    logic         credit_err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    out_port_alloc #(
        .N_IN        (N),
        .CREDIT_DEPTH(4),
        .CNT_W       (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_vc     (in_vc),
        .in_tail   (in_tail),
        .link_up   (link_up),
        .credit_ret(credit_ret),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_vc    (out_vc),
        .out_tail  (out_tail),
        .locked    (locked),
        .credit_err(credit_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are stable here.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle;
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // ---------------- reset ----------------
        rst_n      = 1'b0;
        req        = 4'b1111;
        in_vc      = '0;
        in_tail    = '0;
        link_up    = 1'b1;
        credit_ret = 2'b00;
        tick;
        tick;
        check_eq("rst_gnt",        32'(gnt), 32'h0);
        check_eq("rst_out_valid",  32'(out_valid), 32'h0);
        check_eq("rst_out_vc",     32'(out_vc), 32'h0);
        check_eq("rst_out_tail",   32'(out_tail), 32'h0);
        check_eq("rst_locked",     32'(locked), 32'h0);
        check_eq("rst_credit_err", 32'(credit_err), 32'h0);
        req   = '0;
        rst_n = 1'b1;
        tick;

        // ---------------- single-flit packets, round robin ----------------
        req = 4'b0101; in_tail = 4'b0101; in_vc = 4'b0000;
        settle;
        check_eq("t1_gnt_c1", 32'(gnt), 32'h1);
        tick;
        check_eq("t1_valid_c2", 32'(out_valid), 32'h1);
        check_eq("t1_tail_c2",  32'(out_tail), 32'h1);
        check_eq("t1_vc_c2",    32'(out_vc), 32'h0);
        settle;
        check_eq("t1_gnt_c2", 32'(gnt), 32'h4);
        tick;
        check_eq("t1_valid_c3", 32'(out_valid), 32'h1);
        req = '0;
        settle;
        check_eq("t1_gnt_idle", 32'(gnt), 32'h0);
        tick;
        check_eq("t1_valid_off", 32'(out_valid), 32'h0);
        check_eq("t1_tail_hold", 32'(out_tail), 32'h1);

        // ---------------- 3-flit packet holds the lock ----------------
        req = 4'b0110; in_vc = 4'b0010; in_tail = 4'b0000;
        settle;
        check_eq("t2_gnt_head",   32'(gnt), 32'h2);
        check_eq("t2_locked_pre", 32'(locked), 32'h0);
        tick;
        check_eq("t2_locked_body", 32'(locked), 32'h1);
        check_eq("t2_valid_head",  32'(out_valid), 32'h1);
        check_eq("t2_vc_head",     32'(out_vc), 32'h1);
        check_eq("t2_tail_head",   32'(out_tail), 32'h0);
        settle;
        check_eq("t2_gnt_body", 32'(gnt), 32'h2);
        tick;
        in_tail = 4'b0010;
        settle;
        check_eq("t2_gnt_tail", 32'(gnt), 32'h2);
        tick;
        check_eq("t2_locked_after", 32'(locked), 32'h0);
        check_eq("t2_tail_out",     32'(out_tail), 32'h1);
        check_eq("t2_vc_out",       32'(out_vc), 32'h1);
        req = 4'b0100; in_tail = 4'b0100; in_vc = 4'b0000;
        settle;
        check_eq("t2_gnt_next", 32'(gnt), 32'h4);
        tick;
        check_eq("t2_next_valid", 32'(out_valid), 32'h1);
        check_eq("t2_next_vc",    32'(out_vc), 32'h0);
        req = '0; in_tail = '0;

        // ---------------- credit exhaustion (VC0 has 1 credit left) ----------------
        req = 4'b0001; in_tail = 4'b0001; in_vc = 4'b0000;
        settle;
        check_eq("t3_gnt_last_cred", 32'(gnt), 32'h1);
        tick;
        check_eq("t3_valid_last", 32'(out_valid), 32'h1);
        credit_ret = 2'b01;
        settle;
        check_eq("t3_gnt_nocred", 32'(gnt), 32'h0);
        tick;
        check_eq("t3_valid_nocred", 32'(out_valid), 32'h0);
        settle;
        check_eq("t3_gnt_ret", 32'(gnt), 32'h1);
        tick;
        credit_ret = 2'b00;
        settle;
        check_eq("t3_gnt_after_both", 32'(gnt), 32'h1);
        tick;
        settle;
        check_eq("t3_gnt_drained", 32'(gnt), 32'h0);
        req = '0; in_tail = '0;
        credit_ret = 2'b11;
        tick; tick; tick;
        credit_ret = 2'b01;
        tick;
        credit_ret = 2'b00;
        check_eq("t3_no_err", 32'(credit_err), 32'h0);

        // ---------------- link down mid-packet ----------------
        req = 4'b0010; in_vc = 4'b0000; in_tail = 4'b0000;
        settle;
        check_eq("t4_gnt_head", 32'(gnt), 32'h2);
        tick;
        check_eq("t4_locked", 32'(locked), 32'h1);
        link_up = 1'b0;
        req     = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            settle;
            check_eq("t4_gnt_down", 32'(gnt), 32'h0);
            tick;
            check_eq("t4_locked_down", 32'(locked), 32'h1);
            check_eq("t4_valid_down",  32'(out_valid), 32'h0);
        end
        link_up = 1'b1;
        in_tail = 4'b0010;
        settle;
        check_eq("t4_resume", 32'(gnt), 32'h2);
        tick;
        check_eq("t4_valid_tail", 32'(out_valid), 32'h1);
        check_eq("t4_out_tail",   32'(out_tail), 32'h1);
        check_eq("t4_unlocked",   32'(locked), 32'h0);
        req = '0; in_tail = '0;

        // ---------------- credit overflow is sticky ----------------
        credit_ret = 2'b10;
        tick;
        check_eq("t5_err_set", 32'(credit_err), 32'h1);
        credit_ret = 2'b00;
        tick; tick;
        check_eq("t5_err_sticky", 32'(credit_err), 32'h1);

        // ---------------- reset mid-packet ----------------
        req = 4'b0100; in_vc = 4'b0100; in_tail = 4'b0000;
        settle;
        check_eq("t5_gnt_head", 32'(gnt), 32'h4);
        tick;
        check_eq("t5_locked", 32'(locked), 32'h1);
        check_eq("t5_vc",     32'(out_vc), 32'h1);
        rst_n = 1'b0;
        req   = 4'b0110;
        settle;
        check_eq("t5_gnt_rst", 32'(gnt), 32'h0);
        tick;
        check_eq("t5_rst_locked", 32'(locked), 32'h0);
        check_eq("t5_rst_valid",  32'(out_valid), 32'h0);
        check_eq("t5_rst_vc",     32'(out_vc), 32'h0);
        check_eq("t5_rst_tail",   32'(out_tail), 32'h0);
        check_eq("t5_rst_err",    32'(credit_err), 32'h0);
        rst_n = 1'b1;

        // ---------------- VC priority (rr_ptr = 3 after reset) ----------------
        req = 4'b0011; in_vc = 4'b0010; in_tail = 4'b0011;
        settle;
`ifdef ESCAPE_PRIO_EN
        check_eq("t6_gnt_prio", 32'(gnt), 32'h2);
`else
        check_eq("t6_gnt_prio", 32'(gnt), 32'h1);
`endif
        tick;
        check_eq("t6_valid", 32'(out_valid), 32'h1);
`ifdef ESCAPE_PRIO_EN
        check_eq("t6_vc", 32'(out_vc), 32'h1);
`else
        check_eq("t6_vc", 32'(out_vc), 32'h0);
`endif
        check_eq("t6_locked", 32'(locked), 32'h0);
        req = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
